// File: rtl/reg_xfer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_xfer_pkg : shared encodings for the register-transfer sequencer  |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
package reg_xfer_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 2;

  typedef enum logic [1:0] {
    OP_LDI  = 2'b00,
    OP_MOV  = 2'b01,
    OP_SWAP = 2'b10,
    OP_RD   = 2'b11
  } op_e;

  typedef logic [2:0] state_t;

  localparam state_t IDLE = 3'd0;
  localparam state_t RD_A = 3'd1;
  localparam state_t RD_B = 3'd2;
  localparam state_t WR_A = 3'd3;
  localparam state_t WR_B = 3'd4;

endpackage : reg_xfer_pkg
`default_nettype wire

// File: rtl/reg_xfer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_xfer_ctrl : expands LDI/MOV/SWAP/RD into register-file cycles    |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module reg_xfer_ctrl
  import reg_xfer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              done,
  output logic              busy,
  output logic [DATA_W-1:0] rd_data,
  output logic              rf_wr,
  output logic              rf_rd,
  output logic [ADDR_W-1:0] rf_ra,
  output logic [DATA_W-1:0] rf_din,
  input  logic [DATA_W-1:0] rf_x
);

  state_t              state_q, state_d;
  op_e                 op_q, op_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [DATA_W-1:0]   tmp_a_q, tmp_a_d;
  logic [DATA_W-1:0]   tmp_b_q, tmp_b_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                done_q, done_d;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    dst_d     = dst_q;
    src_d     = src_q;
    imm_d     = imm_q;
    tmp_a_d   = tmp_a_q;
    tmp_b_d   = tmp_b_q;
    rd_data_d = rd_data_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = op_e'(cmd_op);
          dst_d   = cmd_dst;
          src_d   = cmd_src;
          imm_d   = cmd_imm;
          state_d = (op_e'(cmd_op) == OP_LDI) ? WR_A : RD_A;
        end
      end
      RD_A: begin
        tmp_a_d = rf_x;
        case (op_q)
          OP_MOV:  state_d = WR_A;
          OP_SWAP: state_d = RD_B;
          default: begin
            rd_data_d = rf_x;
            state_d   = IDLE;
            done_d    = 1'b1;
          end
        endcase
      end
      RD_B: begin
        tmp_b_d = rf_x;
        state_d = WR_A;
      end
      WR_A: begin
        if (op_q == OP_SWAP) begin
          state_d = WR_B;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      WR_B: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= OP_LDI;
      dst_q     <= '0;
      src_q     <= '0;
      imm_q     <= '0;
      tmp_a_q   <= '0;
      tmp_b_q   <= '0;
      rd_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      dst_q     <= dst_d;
      src_q     <= src_d;
      imm_q     <= imm_d;
      tmp_a_q   <= tmp_a_d;
      tmp_b_q   <= tmp_b_d;
      rd_data_q <= rd_data_d;
      done_q    <= done_d;
    end
  end

  // Port drive depends only on flops so it is settled well before the RF negedge.
  always_comb begin
    rf_wr  = 1'b1;
    rf_rd  = 1'b0;
    rf_ra  = '0;
    rf_din = '0;
    case (state_q)
      RD_A: rf_ra = src_q;
      RD_B: rf_ra = dst_q;
      WR_A: begin
        rf_wr  = 1'b0;
        rf_rd  = 1'b1;
        rf_ra  = dst_q;
        rf_din = (op_q == OP_LDI) ? imm_q : tmp_a_q;
      end
      WR_B: begin
        rf_wr  = 1'b0;
        rf_rd  = 1'b1;
        rf_ra  = src_q;
        rf_din = tmp_b_q;
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign rd_data   = rd_data_q;

endmodule : reg_xfer_ctrl
`default_nettype wire

// File: tb/tb_reg_xfer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_reg_xfer_ctrl : randomized bench with a command-level RF model    |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
module tb_reg_xfer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [1:0] cmd_dst = 2'd0;
  logic [1:0] cmd_src = 2'd0;
  logic [7:0] cmd_imm = 8'h00;
  logic       done, busy;
  logic [7:0] rd_data;
  logic       rf_wr, rf_rd;
  logic [1:0] rf_ra;
  logic [7:0] rf_din;
  logic [7:0] rf_x = 8'h00;

  int total = 0;
  int bad   = 0;
  int viol  = 0;
  int wr_cnt = 0;
  logic [3:0] wr_mask = 4'h0;

  logic [7:0] regs [4];
  logic [7:0] m    [4];
  logic [7:0] m_rd = 8'h00;

  reg_xfer_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_imm(cmd_imm),
    .done(done), .busy(busy), .rd_data(rd_data),
    .rf_wr(rf_wr), .rf_rd(rf_rd), .rf_ra(rf_ra), .rf_din(rf_din), .rf_x(rf_x)
  );

  always #5 clk = ~clk;

  // Behavioural register file: write and X update on the falling edge.
  always @(negedge clk) begin
    if (!rf_wr && rf_rd) begin
      regs[rf_ra] <= rf_din;
      wr_cnt  = wr_cnt + 1;
      wr_mask = wr_mask | (4'b0001 << rf_ra);
    end
    rf_x <= regs[rf_ra];
  end

  function automatic int exp_lat(input logic [1:0] op);
    case (op)
      2'b00:   return 2;
      2'b01:   return 3;
      2'b10:   return 5;
      default: return 2;
    endcase
  endfunction

  task automatic issue(input logic [1:0] op, input logic [1:0] dst, input logic [1:0] src,
                       input logic [7:0] imm, output bit ok);
    cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_imm = imm; cmd_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (cmd_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL accept_timeout: cmd_ready=%b required=1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin lat = k; break; end
      if (cmd_ready !== 1'b0 || busy !== 1'b1) viol++;
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [1:0] dst, input logic [1:0] src,
                         input logic [7:0] imm);
    bit ok;
    int lat, w0, ew;
    logic [3:0] emask;
    logic [7:0] t;
    bit regs_ok;
    case (op)
      2'b00: begin m[dst] = imm; ew = 1; emask = 4'b0001 << dst; end
      2'b01: begin m[dst] = m[src]; ew = 1; emask = 4'b0001 << dst; end
      2'b10: begin
        t = m[src]; m[src] = m[dst]; m[dst] = t;
        ew = 2; emask = (4'b0001 << dst) | (4'b0001 << src);
      end
      default: begin m_rd = m[src]; ew = 0; emask = 4'h0; end
    endcase
    w0 = wr_cnt; wr_mask = 4'h0; viol = 0;
    issue(op, dst, src, imm, ok);
    cmd_valid = 1'b0;
    if (!ok) return;
    wait_done(lat);
    total++;
    if (lat !== exp_lat(op)) begin
      bad++; $display("FAIL latency op=%0d: got=%0d want=%0d", op, lat, exp_lat(op));
    end
    total++;
    if (viol !== 0) begin
      bad++; $display("FAIL busy_ready op=%0d: violations=%0d want=0", op, viol);
    end
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL done_cycle_ready: ready=%b busy=%b want 1/0", cmd_ready, busy);
    end
    total++;
    if ((wr_cnt - w0) !== ew || wr_mask !== emask) begin
      bad++;
      $display("FAIL writes op=%0d: count=%0d mask=%b want count=%0d mask=%b",
               op, wr_cnt - w0, wr_mask, ew, emask);
    end
    regs_ok = 1'b1;
    for (int i = 0; i < 4; i++) if (regs[i] !== m[i]) regs_ok = 1'b0;
    total++;
    if (!regs_ok) begin
      bad++;
      $display("FAIL regfile op=%0d: got=%h %h %h %h want=%h %h %h %h", op,
               regs[0], regs[1], regs[2], regs[3], m[0], m[1], m[2], m[3]);
    end
    total++;
    if (rd_data !== m_rd) begin
      bad++; $display("FAIL rd_data op=%0d: got=%h want=%h", op, rd_data, m_rd);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (rf_wr !== 1'b1 || rf_rd !== 1'b0 || rf_ra !== 2'd0 || rf_din !== 8'h00) begin
      bad++; $display("FAIL reset_rf: wr=%b rd=%b ra=%0d din=%h want 1 0 0 00",
                      rf_wr, rf_rd, rf_ra, rf_din);
    end
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || rd_data !== 8'h00 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ctl: done=%b busy=%b rd_data=%h ready=%b want 0 0 00 1",
                      done, busy, rd_data, cmd_ready);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ldi_rd();
    logic [7:0] want;
    for (int i = 0; i < 4; i++) run_cmd(2'b00, 2'(i), 2'd0, 8'(8'h11 * (i + 1)));
    for (int i = 0; i < 4; i++) begin
      run_cmd(2'b11, 2'd0, 2'(i), 8'h00);
      want = 8'(8'h11 * (i + 1));
      total++;
      if (rd_data !== want) begin
        bad++; $display("FAIL rd_reg%0d: got=%h want=%h", i, rd_data, want);
      end
    end
  endtask

  task automatic test_mov();
    run_cmd(2'b01, 2'd3, 2'd1, 8'h00);
    total++;
    if (regs[3] !== 8'h22 || regs[1] !== 8'h22) begin
      bad++; $display("FAIL mov_r3_r1: r3=%h r1=%h want 22 22", regs[3], regs[1]);
    end
  endtask

  task automatic test_swap();
    run_cmd(2'b10, 2'd0, 2'd2, 8'h00);
    total++;
    if (regs[0] !== 8'h33 || regs[2] !== 8'h11) begin
      bad++; $display("FAIL swap_r0_r2: r0=%h r2=%h want 33 11", regs[0], regs[2]);
    end
    run_cmd(2'b10, 2'd1, 2'd1, 8'h00);
    total++;
    if (regs[1] !== 8'h22) begin
      bad++; $display("FAIL swap_r1_r1: r1=%h want 22", regs[1]);
    end
  endtask

  task automatic test_reset_mid_swap();
    bit ok;
    int seen_done, not_ready;
    run_cmd(2'b00, 2'd1, 2'd0, 8'h5A);
    run_cmd(2'b00, 2'd2, 2'd0, 8'hC3);
    issue(2'b10, 2'd1, 2'd2, 8'h00, ok);
    cmd_valid = 1'b0;
    if (!ok) return;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (rf_wr !== 1'b0 || rf_ra !== 2'd2) begin
      bad++; $display("FAIL swap_in_wr_b: rf_wr=%b rf_ra=%0d want 0 2", rf_wr, rf_ra);
    end
    rst = 1'b1;
    #1;
    total++;
    if (rf_wr !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL async_reset: rf_wr=%b busy=%b done=%b want 1 0 0", rf_wr, busy, done);
    end
    m[1] = m[2];
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    seen_done = 0; not_ready = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done !== 1'b0) seen_done++;
      if (cmd_ready !== 1'b1) not_ready++;
    end
    total++;
    if (seen_done !== 0 || not_ready !== 0) begin
      bad++; $display("FAIL reset_abort: done_cycles=%0d not_ready_cycles=%0d want 0 0",
                      seen_done, not_ready);
    end
    total++;
    if (regs[1] !== 8'hC3 || regs[2] !== 8'hC3) begin
      bad++; $display("FAIL abort_regs: r1=%h r2=%h want c3 c3", regs[1], regs[2]);
    end
    m_rd = 8'h00;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int lat;
    m[0] = 8'hA5; m_rd = 8'hA5;
    viol = 0;
    issue(2'b00, 2'd0, 2'd0, 8'hA5, ok);
    if (!ok) return;
    cmd_op = 2'b11; cmd_src = 2'd0;
    wait_done(lat);
    total++;
    if (lat !== 2 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_first: latency=%0d ready=%b want 2 1", lat, cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL b2b_accept: busy=%b done=%b want 1 0", busy, done);
    end
    wait_done(lat);
    total++;
    if (lat !== 2 || rd_data !== 8'hA5) begin
      bad++; $display("FAIL b2b_rd: latency=%0d rd_data=%h want 2 a5", lat, rd_data);
    end
    total++;
    if (viol !== 0) begin
      bad++; $display("FAIL b2b_busy_ready: violations=%0d want 0", viol);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL done_width: done=%b want 0", done);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_cmd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin regs[i] = 8'h00; m[i] = 8'h00; end
    test_reset();
    test_ldi_rd();
    test_mov();
    test_swap();
    test_reset_mid_swap();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_reg_xfer_ctrl
`default_nettype wire
